// File: rtl/xor_serial_sequencer_pkg.sv
// Shared definitions for the bit-serial XOR sequencer.
//   state_e   : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   cnt_width : width of the RUN-cycle counter, max(1, clog2(w))
package xor_serial_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // clog2 returns 0 for w=1, but the counter still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/xor_serial_sequencer_gate.sv
// Gate-level XOR built from four NAND gates; the single datapath gate
// time-shared by xor_serial_sequencer.
//   x, y : operand bits
//   z    : x XOR y
module xor_serial_sequencer_gate (
  input  logic x,
  input  logic y,
  output logic z
);

  logic n_xy;
  logic n_x;
  logic n_y;

  assign n_xy = ~(x & y);
  assign n_x  = ~(x & n_xy);
  assign n_y  = ~(y & n_xy);
  assign z    = ~(n_x & n_y);

endmodule

// File: rtl/xor_serial_sequencer.sv
// Bit-serial XOR sequencer: accepts an operand pair over a valid/ready
// handshake, computes a XOR b one bit per clock through a single NAND-built
// XOR gate, and returns the result plus its parity over a valid/ready
// handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b sampled on handshake)
//   out_valid / out_ready: result handshake (q, parity held while valid)
//   busy                 : high while a pair is in flight (RUN or DONE)
module xor_serial_sequencer
  import xor_serial_sequencer_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic         parity,
  output logic         busy
);

  localparam int unsigned    CntW    = cnt_width(W);
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  state_e          state_q;
  logic [W-1:0]    sa_q;
  logic [W-1:0]    sb_q;
  logic [W-1:0]    res_q;
  logic [CntW-1:0] cnt_q;
  logic            par_q;
  logic            gate_bit;

  xor_serial_sequencer_gate u_gate (
    .x (sa_q[0]),
    .y (sb_q[0]),
    .z (gate_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // in_ready is high throughout IDLE, so in_valid alone is the handshake.
          if (in_valid) begin
            sa_q    <= a;
            sb_q    <= b;
            res_q   <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          // New bit enters at the MSB; after W shifts bit 0 lands at the LSB.
          res_q <= (res_q >> 1) | (W'(gate_bit) << (W - 1));
          par_q <= par_q ^ gate_bit;
          if (cnt_q == CntLast) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // All outputs decode directly from registers.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign q         = res_q;
  assign parity    = par_q;

endmodule
